// File: rtl/input_debounce_sync_pkg.sv
// Shared debounce state encoding and counter sizing helper.
package input_debounce_sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } debounce_state_t;

  // Counter width able to hold 0..cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debounce_sync_sync_chain.sv
// Plain flop-chain synchroniser for a single-bit level crossing into clk.
module sync_chain #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ff <= {STAGES{RESET_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debounce_sync.sv
// Synchronises and debounces one raw level input; emits the clean level
// plus one-cycle rise/fall events on accepted transitions.
module input_debounce_sync
  import input_debounce_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic raw_in,
  input  logic en,
  output logic x_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam debounce_state_t RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic            s;
  debounce_state_t state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic            x_n, rise_n, fall_n, busy_n;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_b (rst_b),
    .d     (raw_in),
    .q     (s)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      x_out      <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      x_out      <= x_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      busy       <= busy_n;
    end
  end

  // Count consecutive qualifying samples; any break falls back to the held level.
  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    x_n     = x_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s && en) begin
          state_n = QUAL_HI;
          cnt_n   = CNT_W'(1);
        end
      end
      QUAL_HI: begin
        if (s && en) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_n = STABLE_HI;
            x_n     = 1'b1;
            rise_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end else begin
          state_n = STABLE_LO;
        end
      end
      STABLE_HI: begin
        if (!s && en) begin
          state_n = QUAL_LO;
          cnt_n   = CNT_W'(1);
        end
      end
      QUAL_LO: begin
        if (!s && en) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_n = STABLE_LO;
            x_n     = 1'b0;
            fall_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end else begin
          state_n = STABLE_HI;
        end
      end
      default: state_n = x_out ? STABLE_HI : STABLE_LO;
    endcase
    busy_n = (state_n == QUAL_HI) || (state_n == QUAL_LO);
  end

endmodule
